// File: rtl/sobel_sched_pkg.sv
// sobel_sched_pkg: state encoding, processor timing defaults and the raster
// address helper shared by the Sobel scan scheduler files.
package sobel_sched_pkg;

  localparam int SOBEL_PERIOD_DEFAULT  = 10;
  localparam int SOBEL_LATENCY_DEFAULT = 5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ALIGN     = 3'd1;
  localparam logic [2:0] ST_SCAN      = 3'd2;
  localparam logic [2:0] ST_DRAIN     = 3'd3;
  localparam logic [2:0] ST_HOST_ADDR = 3'd4;
  localparam logic [2:0] ST_HOST_DATA = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // Raster address of (x, y); callers truncate to their address width.
  function automatic logic [31:0] coord_to_addr(input logic [15:0] x,
                                                input logic [15:0] y,
                                                input int unsigned width);
    return 32'(y) * width + 32'(x);
  endfunction

endpackage

// File: rtl/sobel_capture_delay.sv
// sobel_capture_delay: fixed-depth valid+address shift line that lines each
// scored pixel's address up with the processor's delayed edge result.
module sobel_capture_delay
  import sobel_sched_pkg::*;
#(
  parameter int LATENCY    = SOBEL_LATENCY_DEFAULT,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  empty
);

  localparam logic [LATENCY-1:0] HEAD_MASK = LATENCY'(1) << (LATENCY - 1);

  logic [LATENCY-1:0]    valid;
  logic [ADDR_WIDTH-1:0] addr_q [LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      for (int i = 0; i < LATENCY; i++) addr_q[i] <= '0;
    end else begin
      valid[0]  <= push;
      addr_q[0] <= push_addr;
      for (int i = 1; i < LATENCY; i++) begin
        valid[i]  <= valid[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid[LATENCY-1];
  assign out_addr  = addr_q[LATENCY-1];
  // Empty once the entry leaving this cycle is the last one in flight.
  assign empty     = !push && ((valid & ~HEAD_MASK) == '0);

endmodule

// File: rtl/sobel_scan_scheduler.sv
// sobel_scan_scheduler: walks sobel_processor across the frame, writes the edge
// map and shares the BRAM read port with a host. Optional ROI scan: SOBEL_SCHED_ROI_EN.
module sobel_scan_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int IMG_WIDTH     = 1280,
  parameter int IMG_HEIGHT    = 720,
  parameter int PIXEL_BITS    = 24,
  parameter int ADDR_WIDTH    = 20,
  parameter int SOBEL_PERIOD  = SOBEL_PERIOD_DEFAULT,
  parameter int SOBEL_LATENCY = SOBEL_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
`ifdef SOBEL_SCHED_ROI_EN
  input  logic [15:0]           roi_x0,
  input  logic [15:0]           roi_y0,
  input  logic [15:0]           roi_x1,
  input  logic [15:0]           roi_y1,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count,
  output logic                  sob_reset,
  output logic [31:0]           x_center,
  output logic [31:0]           y_center,
  input  logic [ADDR_WIDTH-1:0] sob_rd_addr,
  input  logic                  edge_detected,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [PIXEL_BITS-1:0] bram_rd_data,
  output logic                  edge_wr_en,
  output logic [ADDR_WIDTH-1:0] edge_wr_addr,
  output logic                  edge_wr_data,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [PIXEL_BITS-1:0] host_rdata
);

  localparam int PH_W = (SOBEL_PERIOD > 1) ? $clog2(SOBEL_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SOBEL_PERIOD - 1);

  logic [2:0]            state;
  logic [PH_W-1:0]       phase;
  logic [15:0]           x, y, x_adv, y_adv;
  logic [15:0]           x_first, x_last, y_last, start_x, start_y;
  logic                  roi_empty;
  logic                  drain_end, from_scan;
  logic                  calc, last_pixel;
  logic                  cap_valid, cap_empty;
  logic [ADDR_WIDTH-1:0] cap_addr, scan_addr;

`ifdef SOBEL_SCHED_ROI_EN
  // Rectangle bounds are frozen at an accepted start so the host cannot move them mid-frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_first   <= '0;
      x_last    <= '0;
      y_last    <= '0;
      roi_empty <= 1'b0;
    end else if (state == ST_IDLE && !host_req && start) begin
      x_first   <= roi_x0;
      x_last    <= roi_x1;
      y_last    <= roi_y1;
      roi_empty <= (roi_x1 < roi_x0) || (roi_y1 < roi_y0);
    end
  end

  assign start_x = roi_x0;
  assign start_y = roi_y0;
`else
  assign x_first   = '0;
  assign x_last    = 16'(IMG_WIDTH - 1);
  assign y_last    = 16'(IMG_HEIGHT - 1);
  assign start_x   = '0;
  assign start_y   = '0;
  assign roi_empty = 1'b0;
`endif

  assign calc       = (state == ST_SCAN) && (phase == PH_LAST);
  assign last_pixel = (x == x_last) && (y == y_last);
  assign x_adv      = (x == x_last) ? x_first : x + 16'd1;
  assign y_adv      = (x == x_last) ? y + 16'd1 : y;
  assign scan_addr  = ADDR_WIDTH'(coord_to_addr(x, y, IMG_WIDTH));

  // Coordinates hold through DRAIN on a host preemption and only step past the
  // scored pixel once the host read has been served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      phase       <= '0;
      x           <= '0;
      y           <= '0;
      drain_end   <= 1'b0;
      from_scan   <= 1'b0;
      frame_count <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_req) begin
            from_scan <= 1'b0;
            state     <= ST_HOST_ADDR;
          end else if (start) begin
            x     <= start_x;
            y     <= start_y;
            state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          phase <= '0;
          state <= roi_empty ? ST_DONE : ST_SCAN;
        end
        ST_SCAN: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            if (last_pixel) begin
              drain_end <= 1'b1;
              state     <= ST_DRAIN;
            end else if (host_req) begin
              drain_end <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              x <= x_adv;
              y <= y_adv;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cap_empty) begin
            from_scan <= !drain_end;
            state     <= drain_end ? ST_DONE : ST_HOST_ADDR;
          end
        end
        ST_HOST_ADDR: state <= ST_HOST_DATA;
        ST_HOST_DATA: begin
          host_rdata  <= bram_rd_data;
          host_rvalid <= 1'b1;
          if (from_scan) begin
            x     <= x_adv;
            y     <= y_adv;
            state <= ST_ALIGN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          frame_count <= frame_count + 16'd1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sobel_capture_delay #(
    .LATENCY    (SOBEL_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_capture (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (calc),
    .push_addr (scan_addr),
    .out_valid (cap_valid),
    .out_addr  (cap_addr),
    .empty     (cap_empty)
  );

  always_comb begin
    busy = 1'b1;
    case (state)
      ST_IDLE:                    busy = 1'b0;
      ST_HOST_ADDR, ST_HOST_DATA: busy = from_scan;
      default:                    busy = 1'b1;
    endcase
  end

  assign done         = (state == ST_DONE);
  assign host_gnt     = (state == ST_HOST_ADDR);
  assign bram_rd_addr = (state == ST_HOST_ADDR) ? host_addr : sob_rd_addr;
  assign sob_reset    = !reset_n || (state == ST_ALIGN) ||
                        (state == ST_HOST_ADDR) || (state == ST_HOST_DATA);
  assign x_center     = {16'd0, x};
  assign y_center     = {16'd0, y};
  assign edge_wr_en   = cap_valid;
  assign edge_wr_addr = cap_addr;
  assign edge_wr_data = cap_valid & edge_detected;

endmodule
